// File: rtl/mem_dump_reader.sv
// Streams a window of data memory out MSB-first as bytes over a valid/ready interface.
// Optional trailing XOR checksum byte when DMEM_DUMP_CHECKSUM_EN is defined.
module mem_dump_reader #(
   parameter int NB_WIDTH = 32,
   parameter int NB_ADDR  = 9,
   parameter int NB_DATA  = 8
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [NB_ADDR-1:0]  i_base_addr,
   input  logic [NB_ADDR-2:0]  i_word_count,
   output logic                o_mem_rd_en,
   output logic [NB_ADDR-1:0]  o_mem_addr,
   input  logic [NB_WIDTH-1:0] i_mem_data,
   output logic [NB_DATA-1:0]  o_tx_data,
   output logic                o_tx_valid,
   input  logic                i_tx_ready,
   output logic                o_busy,
   output logic                o_done
);

   localparam int NB_BYTES = NB_WIDTH / NB_DATA;
   localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

   localparam logic [NB_CNT-1:0]  LAST_BYTE  = NB_CNT'(NB_BYTES - 1);
   localparam logic [NB_ADDR-1:0] ADDR_STEP  = NB_ADDR'(NB_WIDTH / 8);
   localparam logic [NB_ADDR-1:0] ALIGN_MASK = ~NB_ADDR'(3);
   localparam logic [NB_ADDR-2:0] ONE_WORD   = (NB_ADDR-1)'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SEND,
`ifdef DMEM_DUMP_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE
   } state_t;

`ifdef DMEM_DUMP_CHECKSUM_EN
   localparam state_t S_TAIL = S_CSUM;
`else
   localparam state_t S_TAIL = S_DONE;
`endif

   state_t              state, state_next;
   logic [NB_ADDR-1:0]  addr, addr_next;
   logic [NB_ADDR-2:0]  words_left, words_next;
   logic [NB_WIDTH-1:0] shift, shift_next;
   logic [NB_CNT-1:0]   byte_cnt, cnt_next;
`ifdef DMEM_DUMP_CHECKSUM_EN
   logic [NB_DATA-1:0]  csum, csum_next;
`endif

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= S_IDLE;
         addr       <= '0;
         words_left <= '0;
         shift      <= '0;
         byte_cnt   <= '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         state      <= state_next;
         addr       <= addr_next;
         words_left <= words_next;
         shift      <= shift_next;
         byte_cnt   <= cnt_next;
`ifdef DMEM_DUMP_CHECKSUM_EN
         csum       <= csum_next;
`endif
      end
   end

   assign o_mem_addr = addr;

   // NOTE: every always_comb output gets a default first, otherwise unassigned paths infer latches.
   always_comb begin
      state_next  = state;
      addr_next   = addr;
      words_next  = words_left;
      shift_next  = shift;
      cnt_next    = byte_cnt;
`ifdef DMEM_DUMP_CHECKSUM_EN
      csum_next   = csum;
`endif
      o_mem_rd_en = 1'b0;
      o_tx_valid  = 1'b0;
      o_tx_data   = shift[NB_WIDTH-1 -: NB_DATA];
      o_busy      = 1'b1;
      o_done      = 1'b0;

      case (state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_start) begin
               addr_next  = i_base_addr & ALIGN_MASK;
               words_next = i_word_count;
`ifdef DMEM_DUMP_CHECKSUM_EN
               csum_next  = '0;
`endif
               state_next = (i_word_count == '0) ? S_TAIL : S_FETCH;
            end
         end

         S_FETCH: begin
            o_mem_rd_en = 1'b1;
            shift_next  = i_mem_data;
            cnt_next    = '0;
            state_next  = S_SEND;
         end

         S_SEND: begin
            o_tx_valid = 1'b1;
            if (i_tx_ready) begin
               shift_next = shift << NB_DATA;
               cnt_next   = byte_cnt + 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
               csum_next  = csum ^ shift[NB_WIDTH-1 -: NB_DATA];
`endif
               if (byte_cnt == LAST_BYTE) begin
                  words_next = words_left - 1'b1;
                  addr_next  = addr + ADDR_STEP;
                  state_next = (words_left == ONE_WORD) ? S_TAIL : S_FETCH;
               end
            end
         end

`ifdef DMEM_DUMP_CHECKSUM_EN
         S_CSUM: begin
            o_tx_valid = 1'b1;
            o_tx_data  = csum;
            if (i_tx_ready) state_next = S_DONE;
         end
`endif

         S_DONE: begin
            o_done     = 1'b1;
            state_next = S_IDLE;
         end

         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed, table-driven bench for mem_dump_reader; honours DMEM_DUMP_CHECKSUM_EN for the
// expected trailing checksum byte.
module tb_mem_dump_reader;

`ifdef DMEM_DUMP_CHECKSUM_EN
   localparam int CSUM_EXTRA = 1;
`else
   localparam int CSUM_EXTRA = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [8:0]  base_addr;
   logic [7:0]  word_count;
   logic        mem_rd_en;
   logic [8:0]  mem_addr;
   logic [31:0] mem_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        done;

   logic [31:0] mem [0:127];

   mem_dump_reader #(.NB_WIDTH(32), .NB_ADDR(9), .NB_DATA(8)) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_start      (start),
      .i_base_addr  (base_addr),
      .i_word_count (word_count),
      .o_mem_rd_en  (mem_rd_en),
      .o_mem_addr   (mem_addr),
      .i_mem_data   (mem_data),
      .o_tx_data    (tx_data),
      .o_tx_valid   (tx_valid),
      .i_tx_ready   (tx_ready),
      .o_busy       (busy),
      .o_done       (done)
   );

   always #5 clk = ~clk;

   assign mem_data = mem[mem_addr[8:2]];

   typedef struct {
      logic [8:0]      base;
      logic [7:0]      count;
      int              nbytes;
      logic [0:7][7:0] b;
      logic [7:0]      csum;
      logic [8:0]      addr0;
      logic [8:0]      addr1;
   } vec_t;

   vec_t vecs [4];

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0] rx_q [$];
   logic [8:0] rd_q [$];
   int         done_cnt;

   // Handshakes are observed mid-cycle; an accepted byte is one where valid&&ready before the edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_valid && tx_ready) rx_q.push_back(tx_data);
         if (mem_rd_en) rd_q.push_back(mem_addr);
         if (done) done_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic clear_obs();
      rx_q.delete();
      rd_q.delete();
      done_cnt = 0;
   endtask

   task automatic launch(input logic [8:0] b, input logic [7:0] c);
      base_addr  = b;
      word_count = c;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int c = 0; c < budget && done_cnt == 0; c++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic verify(input vec_t v);
      int         exp_n;
      logic [7:0] exp_b;
      logic [31:0] got;
      exp_n = v.nbytes + CSUM_EXTRA;
      check("byte_count", rx_q.size(), exp_n);
      for (int i = 0; i < exp_n; i++) begin
         exp_b = (i < v.nbytes) ? v.b[i] : v.csum;
         got   = (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF;
         check($sformatf("byte[%0d]", i), got, {24'h0, exp_b});
      end
      check("done_pulses", done_cnt, 1);
      check("read_count", rd_q.size(), v.count);
      if (v.count > 0) check("first_read_addr", (rd_q.size() > 0) ? {23'h0, rd_q[0]} : 32'hFFFF_FFFF, v.addr0);
      if (v.count > 1) check("second_read_addr", (rd_q.size() > 1) ? {23'h0, rd_q[1]} : 32'hFFFF_FFFF, v.addr1);
      check("idle_after", busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected $finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      mem[4]   = 32'hDEADBEEF;   // 0x010
      mem[5]   = 32'h01020304;   // 0x014
      mem[127] = 32'hA1B2C3D4;   // 0x1FC
      mem[0]   = 32'h11223344;   // 0x000

      // XOR of all data bytes: DEADBEEF -> 0x22, 01020304 -> 0x04, A1B2C3D4 -> 0x04, 11223344 -> 0x44
      vecs[0] = '{9'h010, 8'd2, 8, 64'hDEADBEEF_01020304, 8'h26, 9'h010, 9'h014};
      vecs[1] = '{9'h020, 8'd0, 0, 64'h0,                 8'h00, 9'h000, 9'h000};
      vecs[2] = '{9'h1FC, 8'd2, 8, 64'hA1B2C3D4_11223344, 8'h40, 9'h1FC, 9'h000};
      vecs[3] = '{9'h013, 8'd1, 4, 64'hDEADBEEF_00000000, 8'h22, 9'h010, 9'h000};

      rst        = 1'b1;
      start      = 1'b0;
      base_addr  = '0;
      word_count = '0;
      tx_ready   = 1'b1;
      done_cnt   = 0;
      #1;
      check("rst_valid", tx_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rd_en", mem_rd_en, 1'b0);
      check("rst_addr", mem_addr, 9'h000);
      check("rst_data", tx_data, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Table: each vector dumps at full rate.
      for (int v = 0; v < 4; v++) begin
         clear_obs();
         launch(vecs[v].base, vecs[v].count);
         wait_done(200);
         verify(vecs[v]);
      end

      // Start-to-first-byte latency and FETCH strobe.
      clear_obs();
      launch(9'h010, 8'd1);
      check("lat_rd_en", mem_rd_en, 1'b1);
      check("lat_fetch_addr", mem_addr, 9'h010);
      check("lat_no_valid_yet", tx_valid, 1'b0);
      check("lat_busy", busy, 1'b1);
      @(posedge clk); #1;
      check("lat_valid", tx_valid, 1'b1);
      check("lat_first_byte", tx_data, 8'hDE);
      wait_done(200);
      verify(vecs[3]);

      // Zero-word dump: the cycle after start is DONE (or the checksum byte).
      clear_obs();
      launch(9'h000, 8'd0);
`ifdef DMEM_DUMP_CHECKSUM_EN
      check("zero_csum_valid", tx_valid, 1'b1);
      check("zero_csum_data", tx_data, 8'h00);
`else
      check("zero_done_pulse", done, 1'b1);
      check("zero_no_valid", tx_valid, 1'b0);
`endif
      wait_done(50);
      verify(vecs[1]);

      // Backpressure on the second byte.
      clear_obs();
      launch(9'h010, 8'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp_valid[%0d]", i), tx_valid, 1'b1);
         check($sformatf("bp_data[%0d]", i), tx_data, 8'hAD);
      end
      tx_ready = 1'b1;
      wait_done(200);
      verify(vecs[3]);

      // Reset while sending word 1, then a clean dump.
      clear_obs();
      launch(9'h010, 8'd2);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", tx_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_data", tx_data, 8'h00);
      check("mid_rst_addr", mem_addr, 9'h000);
      check("mid_rst_done", done, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      done_cnt = 0;
      repeat (6) @(posedge clk);
      #1;
      check("mid_rst_no_done", done_cnt, 0);
      clear_obs();
      launch(vecs[0].base, vecs[0].count);
      wait_done(200);
      verify(vecs[0]);

      // Start re-pulsed mid-dump with a different window is ignored.
      clear_obs();
      launch(vecs[0].base, vecs[0].count);
      repeat (3) @(posedge clk);
      #1;
      launch(9'h1FC, 8'd1);
      wait_done(200);
      verify(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
